key_debounce_pulse: RTL and testbench

//  Conditions the board's raw active-low pushbuttons (KEY[3:0]) for the rest of the design.
//  Per key: 2-flop synchroniser, debounce FSM, clean level, one-cycle press/release strobes.

---
 rtl/key_debounce_pkg.sv | 21 ++
 rtl/key_debounce_chan.sv | 150 +++++++++++++++
 rtl/key_debounce_pulse.sv | 42 ++++
 tb/tb_key_debounce_pulse.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default parameters for the KEY[3:0] debounce / strobe block.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        KS_RELEASED    = 2'd0,
        KS_ARM_PRESS   = 2'd1,
        KS_PRESSED     = 2'd2,
        KS_ARM_RELEASE = 2'd3
    } key_state_t;

    localparam int unsigned NUM_KEYS_DEF        = 32'd4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd500000;
    localparam int unsigned REPEAT_DELAY_DEF    = 32'd25000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 32'd5000000;

    // Width of a counter that must be able to hold max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, registered level and strobes.
// Auto-repeat hold counter is present only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    key_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          w_key_low;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int unsigned    HW         = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                      REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [HW-1:0]  HOLD_DELAY = HW'(REPEAT_DELAY - 32'd1);
    localparam logic [HW-1:0]  HOLD_PER   = HW'(REPEAT_PERIOD - 32'd1);

    logic [HW-1:0] r_hold_cnt;
    logic          r_repeating;
    logic [HW-1:0] w_hold_last;

    assign w_hold_last = r_repeating ? HOLD_PER : HOLD_DELAY;
`endif

    assign w_key_low = ~r_sync2;

    // Synchroniser idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM with registered level and one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= KS_RELEASED;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            r_hold_cnt      <= '0;
            r_repeating     <= 1'b0;
`endif
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                KS_RELEASED: begin
                    if (w_key_low) begin
                        r_state <= KS_ARM_PRESS;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                KS_ARM_PRESS: begin
                    if (!w_key_low) begin
                        r_state <= KS_RELEASED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= KS_PRESSED;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        r_hold_cnt    <= '0;
                        r_repeating   <= 1'b0;
`endif
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                KS_PRESSED: begin
                    if (!w_key_low) begin
                        r_state <= KS_ARM_RELEASE;
                        r_cnt   <= CNT_ONE;
                    end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        if (r_hold_cnt == w_hold_last) begin
                            r_press_pulse <= 1'b1;
                            r_hold_cnt    <= '0;
                            r_repeating   <= 1'b1;
                        end else begin
                            r_hold_cnt    <= r_hold_cnt + HW'(1);
                        end
`endif
                        r_cnt <= '0;
                    end
                end
                KS_ARM_RELEASE: begin
                    // Hold counter stays frozen here: no repeat while a release qualifies.
                    if (w_key_low) begin
                        r_state <= KS_PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state         <= KS_RELEASED;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        r_hold_cnt      <= '0;
                        r_repeating     <= 1'b0;
`endif
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_state   <= KS_RELEASED;
                    r_cnt     <= '0;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounced level plus press/release strobes for NUM_KEYS active-low pushbuttons.
// Optional auto-repeat on held keys: define KEY_DEBOUNCE_REPEAT_EN.
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = NUM_KEYS_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [NUM_KEYS-1:0] pressed_o,
    output logic [NUM_KEYS-1:0] press_pulse_o,
    output logic [NUM_KEYS-1:0] release_pulse_o
);

    // Below two cycles a strobe could not be separated from its qualifying window.
    if ((DEBOUNCE_CYCLES < 32'd2) || (REPEAT_DELAY < 32'd2) || (REPEAT_PERIOD < 32'd2)) begin : g_param_check
        $error("key_debounce_pulse: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_key           (key_i[g]),
            .o_pressed       (pressed_o[g]),
            .o_press_pulse   (press_pulse_o[g]),
            .o_release_pulse (release_pulse_o[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse; expected strobes are queued when a key edge is
// driven and checked every cycle. Repeat expectations follow KEY_DEBOUNCE_REPEAT_EN.
module tb_key_debounce_pulse;
    import key_debounce_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = DEB + 2;

    typedef struct {
        int         cyc;
        logic [3:0] pm;
        logic [3:0] rm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    exp_t       sb_q[$];
    logic [3:0] exp_level;
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    key_debounce_pulse #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_i           (key),
        .pressed_o       (pressed),
        .press_pulse_o   (press_pulse),
        .release_pulse_o (release_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [3:0] pm, input logic [3:0] rm);
        exp_t e;
        e.cyc = c;
        e.pm  = pm;
        e.rm  = rm;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    // Per-cycle scoreboard check, sampled on the falling edge.
    always @(negedge clk) begin
        logic [3:0] exp_p;
        logic [3:0] exp_r;
        exp_p = 4'b0000;
        exp_r = 4'b0000;
        if (rst_n === 1'b1) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) void'(sb_q.pop_front());
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                exp_p     = sb_q[0].pm;
                exp_r     = sb_q[0].rm;
                exp_level = (exp_level | exp_p) & ~exp_r;
                void'(sb_q.pop_front());
            end
            chk("press_pulse", press_pulse, exp_p);
            chk("release_pulse", release_pulse, exp_r);
            chk("pressed_level", pressed, exp_level);
        end
    end

    initial begin
        int a;
        rst_n     = 1'b0;
        key       = 4'hF;
        exp_level = 4'b0000;
        step(3);
        chk("reset_pressed", pressed, 4'b0000);
        chk("reset_press_pulse", press_pulse, 4'b0000);
        chk("reset_release_pulse", release_pulse, 4'b0000);
        rst_n = 1'b1;
        step(50);

        // Clean press then clean release on key 0.
        key[0] = 1'b0;
        push(cyc + LAT, 4'b0001, 4'b0000);
        step(12);
        key[0] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0001);
        step(12);

        // Short press glitch on key 1 is rejected; then a real press with a release bounce.
        key[1] = 1'b0;
        step(3);
        key[1] = 1'b1;
        step(10);
        key[1] = 1'b0;
        push(cyc + LAT, 4'b0010, 4'b0000);
        step(10);
        key[1] = 1'b1;
        step(2);
        key[1] = 1'b0;
        step(10);
        key[1] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0010);
        step(10);

        // Keys 2 and 3 together.
        key[3:2] = 2'b00;
        push(cyc + LAT, 4'b1100, 4'b0000);
        step(10);
        key[3:2] = 2'b11;
        push(cyc + LAT, 4'b0000, 4'b1100);
        step(10);

        // Reset in the middle of qualifying a press; key stays low through reset.
        key[0] = 1'b0;
        step(3);
        rst_n     = 1'b0;
        exp_level = 4'b0000;
        #1;
        chk("midreset_pressed", pressed, 4'b0000);
        chk("midreset_press_pulse", press_pulse, 4'b0000);
        step(2);
        rst_n = 1'b1;
        push(cyc + LAT, 4'b0001, 4'b0000);
        step(12);
        key[0] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0001);
        step(12);

        // Long hold on key 0; released so qualification covers the slot at accept+60.
        key[0] = 1'b0;
        a = cyc + LAT;
        push(a, 4'b0001, 4'b0000);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        for (int k = 0; k < 5; k++) push(a + RD + k * RP, 4'b0001, 4'b0000);
`endif
        step(LAT + 57);
        key[0] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0001);
        step(12);

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drained observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
